// File: rtl/time_counter_p_if.sv
// Bundle of the button, display and alarm signals of the time-of-day counter.
// No valid/ready pairs: set and inc are level signals whose rising edges the counter detects itself.
interface time_counter_p_if;
    logic       set;
    logic       inc;
    logic       mode_24h;
    logic       alarm_en;
    logic [4:0] alarm_h;
    logic [5:0] alarm_m;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
    logic       setting_h;
    logic       setting_m;
    logic       sec_tick;
    logic       alarm_hit;
    logic [1:0] state_dbg;

    modport master (
        output set, inc, mode_24h, alarm_en, alarm_h, alarm_m,
        input  hours, minutes, seconds, am_pm, setting_h, setting_m,
               sec_tick, alarm_hit, state_dbg
    );

    modport slave (
        input  set, inc, mode_24h, alarm_en, alarm_h, alarm_m,
        output hours, minutes, seconds, am_pm, setting_h, setting_m,
               sec_tick, alarm_hit, state_dbg
    );
endinterface

// File: rtl/time_counter_p.sv
// Single-clock time-of-day counter: internal 1 Hz prescaler, 12/24-hour display,
// RUN/SET_H/SET_M set mode and an alarm-match pulse.
module time_counter_p #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic             project_clk,
    input  logic             rst,
    time_counter_p_if.slave  bus
);
    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic [4:0]         h24;
    logic [5:0]         minutes;
    logic [5:0]         seconds;
    logic               set_q;
    logic               inc_q;
    logic               sec_tick;
    logic               alarm_hit;

    logic               set_edge;
    logic               inc_edge;
    logic               tick;
    logic [4:0]         nxt_h;
    logic [5:0]         nxt_m;
    logic [5:0]         nxt_s;
    logic               alarm_match;
    logic [4:0]         h_mod;
    logic [4:0]         h12;

    always_comb begin
        set_edge = bus.set & ~set_q;
        inc_edge = bus.inc & ~inc_q;
        tick     = (state == ST_RUN) && (presc == PRESC_MAX);

        // Time after one second, with the full seconds -> minutes -> hours carry chain.
        nxt_s = seconds + 6'd1;
        nxt_m = minutes;
        nxt_h = h24;
        if (seconds == 6'd59) begin
            nxt_s = 6'd0;
            if (minutes == 6'd59) begin
                nxt_m = 6'd0;
                nxt_h = (h24 == 5'd23) ? 5'd0 : h24 + 5'd1;
            end else begin
                nxt_m = minutes + 6'd1;
            end
        end

        alarm_match = bus.alarm_en && (nxt_h == bus.alarm_h) &&
                      (nxt_m == bus.alarm_m) && (nxt_s == 6'd0);

        h_mod = (h24 >= 5'd12) ? h24 - 5'd12 : h24;
        h12   = (h_mod == 5'd0) ? 5'd12 : h_mod;
    end

    always_ff @(posedge project_clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            presc     <= '0;
            h24       <= 5'd0;
            minutes   <= 6'd0;
            seconds   <= 6'd0;
            set_q     <= 1'b0;
            inc_q     <= 1'b0;
            sec_tick  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            set_q     <= bus.set;
            inc_q     <= bus.inc;
            sec_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            if (set_edge) begin
                // A set edge takes priority over both a coincident tick and an inc edge.
                case (state)
                    ST_RUN: begin
                        state   <= ST_SET_H;
                        seconds <= 6'd0;
                        presc   <= '0;
                    end
                    ST_SET_H: state <= ST_SET_M;
                    ST_SET_M: begin
                        state <= ST_RUN;
                        presc <= '0;
                    end
                    default: begin
                        state <= ST_RUN;
                        presc <= '0;
                    end
                endcase
            end else begin
                case (state)
                    ST_RUN: begin
                        if (tick) begin
                            presc     <= '0;
                            seconds   <= nxt_s;
                            minutes   <= nxt_m;
                            h24       <= nxt_h;
                            sec_tick  <= 1'b1;
                            alarm_hit <= alarm_match;
                        end else begin
                            presc <= presc + PRESC_W'(1);
                        end
                    end
                    ST_SET_H: begin
                        if (inc_edge) h24 <= (h24 == 5'd23) ? 5'd0 : h24 + 5'd1;
                    end
                    ST_SET_M: begin
                        if (inc_edge) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

    assign bus.hours     = bus.mode_24h ? h24 : h12;
    assign bus.minutes   = minutes;
    assign bus.seconds   = seconds;
    assign bus.am_pm     = (h24 >= 5'd12);
    assign bus.setting_h = (state == ST_SET_H);
    assign bus.setting_m = (state == ST_SET_M);
    assign bus.sec_tick  = sec_tick;
    assign bus.alarm_hit = alarm_hit;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_time_counter_p.sv
// Bench for time_counter_p: vector table, directed corner sequences and a randomized run,
// all checked against a seconds-of-day reference model.
module tb_time_counter_p;
    localparam int CLK_HZ = 4;

    logic clk = 1'b0;
    logic rst;

    time_counter_p_if bus();

    time_counter_p #(.CLK_HZ(CLK_HZ)) dut (
        .project_clk (clk),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int alarm_count = 0;
    logic [31:0] exp_q[$];

    // Reference model: time as seconds of day, mode 0=RUN 1=SET_H 2=SET_M.
    int m_t, m_mode, m_cnt;
    bit m_set_q, m_inc_q, m_tick, m_alarm;

    typedef struct {
        logic set;
        logic inc;
        logic m24;
        int   eh;
        int   em;
        int   es;
        logic esh;
        logic esm;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic s, logic i, logic m24, int eh, int em, int es, logic esh, logic esm);
        vec_t v;
        v.set = s; v.inc = i; v.m24 = m24;
        v.eh = eh; v.em = em; v.es = es; v.esh = esh; v.esm = esm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_t = 0; m_mode = 0; m_cnt = 0;
        m_set_q = 0; m_inc_q = 0; m_tick = 0; m_alarm = 0;
    endfunction

    function automatic void model_clock();
        bit se, ie;
        int h, m;
        se = bus.set && !m_set_q;
        ie = bus.inc && !m_inc_q;
        m_set_q = bus.set;
        m_inc_q = bus.inc;
        m_tick  = 0;
        m_alarm = 0;
        if (se) begin
            m_mode = (m_mode + 1) % 3;
            m_cnt  = 0;
            if (m_mode == 1) m_t = m_t - (m_t % 60);
        end else if (m_mode == 0) begin
            if (m_cnt == CLK_HZ - 1) begin
                m_cnt  = 0;
                m_t    = (m_t + 1) % 86400;
                m_tick = 1;
                m_alarm = bus.alarm_en && (m_t / 3600 == int'(bus.alarm_h)) &&
                          ((m_t / 60) % 60 == int'(bus.alarm_m)) && (m_t % 60 == 0);
            end else begin
                m_cnt++;
            end
        end else if (ie) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            if (m_mode == 1) m_t = ((h + 1) % 24) * 3600 + m * 60 + m_t % 60;
            else             m_t = h * 3600 + ((m + 1) % 60) * 60 + m_t % 60;
        end
    endfunction

    function automatic logic [31:0] exp_pack();
        int h, hd;
        h  = m_t / 3600;
        hd = bus.mode_24h ? h : ((h % 12 == 0) ? 12 : h % 12);
        return {10'd0, 5'(hd), 6'((m_t / 60) % 60), 6'(m_t % 60), (h >= 12),
                (m_mode == 1), (m_mode == 2), m_tick, m_alarm};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {10'd0, bus.hours, bus.minutes, bus.seconds, bus.am_pm,
                bus.setting_h, bus.setting_m, bus.sec_tick, bus.alarm_hit};
    endfunction

    task automatic step_cycle();
        @(posedge clk);
        model_clock();
        #1;
        exp_q.push_back(exp_pack());
        check($sformatf("cycle%0d_outputs", cyc), dut_pack(), exp_q.pop_front());
        alarm_count += int'(bus.alarm_hit);
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic pulse_set();
        bus.set = 1'b1; step_cycle();
        bus.set = 1'b0; step_cycle();
    endtask

    task automatic pulse_inc();
        bus.inc = 1'b1; step_cycle();
        bus.inc = 1'b0; step_cycle();
    endtask

    // From RUN: set h:m through SET_H/SET_M and return to RUN with seconds at 0.
    task automatic set_time(input int h, input int m);
        pulse_set();
        repeat ((h - m_t / 3600 + 24) % 24) pulse_inc();
        pulse_set();
        repeat ((m - (m_t / 60) % 60 + 60) % 60) pulse_inc();
        pulse_set();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tick_cnt, a0, nxt;

        bus.set = 1'b0; bus.inc = 1'b0; bus.mode_24h = 1'b0;
        bus.alarm_en = 1'b0; bus.alarm_h = 5'd0; bus.alarm_m = 6'd0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hours12", bus.hours, 12);
        check("rst_minutes", bus.minutes, 0);
        check("rst_seconds", bus.seconds, 0);
        check("rst_am_pm", bus.am_pm, 0);
        check("rst_setting", {bus.setting_h, bus.setting_m}, 0);
        check("rst_pulses", {bus.sec_tick, bus.alarm_hit}, 0);
        check("rst_state", bus.state_dbg, 0);
        bus.mode_24h = 1'b1;
        #1;
        check("rst_hours24", bus.hours, 0);
        bus.mode_24h = 1'b0;
        rst = 1'b1;
        model_reset();

        tick_cnt = 0;
        repeat (CLK_HZ) begin
            step_cycle();
            tick_cnt += int'(bus.sec_tick);
        end
        check("first_sec", bus.seconds, 1);
        check("first_tick_count", tick_cnt, 1);

        vecs[0]  = mk(1, 0, 1, 2'd0, 0, 0, 1, 0);
        vecs[1]  = mk(0, 1, 1, 1, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 1, 1, 0, 0, 1, 0);
        vecs[3]  = mk(0, 1, 1, 2, 0, 0, 1, 0);
        vecs[4]  = mk(0, 0, 1, 2, 0, 0, 1, 0);
        vecs[5]  = mk(1, 1, 1, 2, 0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 1, 2, 0, 0, 0, 1);
        vecs[7]  = mk(0, 1, 1, 2, 1, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 2, 1, 0, 0, 1);
        vecs[9]  = mk(1, 0, 0, 2, 1, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 2, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 2, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 2, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 2, 1, 1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            bus.set = vecs[i].set;
            bus.inc = vecs[i].inc;
            bus.mode_24h = vecs[i].m24;
            step_cycle();
            check($sformatf("vec%0d_hours", i), bus.hours, vecs[i].eh);
            check($sformatf("vec%0d_minutes", i), bus.minutes, vecs[i].em);
            check($sformatf("vec%0d_seconds", i), bus.seconds, vecs[i].es);
            check($sformatf("vec%0d_setting_h", i), bus.setting_h, vecs[i].esh);
            check($sformatf("vec%0d_setting_m", i), bus.setting_m, vecs[i].esm);
        end
        bus.set = 1'b0; bus.inc = 1'b0; bus.mode_24h = 1'b0;

        // 11:59:59 -> 12:00:00 PM
        set_time(11, 59);
        run_cycles(59 * CLK_HZ - 1);
        check("noon_pre_sec", bus.seconds, 59);
        check("noon_pre_hours", bus.hours, 11);
        run_cycles(CLK_HZ);
        check("noon_hours", bus.hours, 12);
        check("noon_min_sec", {bus.minutes, bus.seconds}, 0);
        check("noon_am_pm", bus.am_pm, 1);

        // 23:59:59 -> 00:00:00
        set_time(23, 59);
        run_cycles(59 * CLK_HZ - 1);
        check("midn_pre_pm", bus.am_pm, 1);
        run_cycles(CLK_HZ);
        check("midn_hours12", bus.hours, 12);
        check("midn_min_sec", {bus.minutes, bus.seconds}, 0);
        check("midn_am_pm", bus.am_pm, 0);
        bus.mode_24h = 1'b1;
        #1;
        check("midn_hours24", bus.hours, 0);

        // SET_M wrap without carry, then set edge coinciding with a tick
        pulse_set();
        pulse_set();
        repeat (59) pulse_inc();
        check("setm_min59", bus.minutes, 59);
        check("setm_state", bus.setting_m, 1);
        pulse_inc();
        check("setm_wrap_min", bus.minutes, 0);
        check("setm_wrap_hour", bus.hours, 0);
        pulse_set();
        run_cycles(5 * CLK_HZ - 1);
        check("run_sec5", bus.seconds, 5);
        run_cycles(CLK_HZ - 1);
        bus.set = 1'b1;
        step_cycle();
        check("set_tick_seth", bus.setting_h, 1);
        check("set_tick_no_tick", bus.sec_tick, 0);
        check("set_tick_sec", bus.seconds, 0);
        bus.set = 1'b0;
        step_cycle();
        pulse_set();
        pulse_set();
        bus.mode_24h = 1'b0;

        // Alarm at 07:30
        bus.alarm_h = 5'd7; bus.alarm_m = 6'd30; bus.alarm_en = 1'b1;
        set_time(7, 29);
        run_cycles(59 * CLK_HZ - 1);
        a0 = alarm_count;
        run_cycles(2 * CLK_HZ);
        check("alarm_hit_count", alarm_count - a0, 1);
        check("alarm_minute", bus.minutes, 30);
        a0 = alarm_count;
        set_time(7, 30);
        run_cycles(2 * CLK_HZ);
        check("alarm_set_no_fire", alarm_count - a0, 0);
        bus.alarm_en = 1'b0;
        set_time(7, 29);
        run_cycles(59 * CLK_HZ - 1);
        a0 = alarm_count;
        run_cycles(2 * CLK_HZ);
        check("alarm_disabled", alarm_count - a0, 0);

        // Asynchronous reset in SET_M
        pulse_set();
        pulse_inc();
        pulse_set();
        pulse_inc();
        check("pre_rst_setm", bus.setting_m, 1);
        check("pre_rst_min", bus.minutes, 31);
        #2;
        rst = 1'b0;
        #1;
        check("async_hours", bus.hours, 12);
        check("async_min_sec", {bus.minutes, bus.seconds}, 0);
        check("async_am_pm", bus.am_pm, 0);
        check("async_setting", {bus.setting_h, bus.setting_m}, 0);
        check("async_state", bus.state_dbg, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            bus.set = (m_mode == 0) ? ($urandom_range(0, 999) < 3) : ($urandom_range(0, 99) < 4);
            bus.inc = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 2) bus.mode_24h = ~bus.mode_24h;
            if (i % 200 == 0) begin
                bus.alarm_en = ($urandom_range(0, 3) != 0);
                nxt = (m_t / 60 + 1) % 1440;
                if ($urandom_range(0, 4) == 0) begin
                    bus.alarm_h = 5'($urandom_range(0, 31));
                    bus.alarm_m = 6'($urandom_range(0, 59));
                end else begin
                    bus.alarm_h = 5'(nxt / 60);
                    bus.alarm_m = 6'(nxt % 60);
                end
            end
            step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
